// File: rtl/data_cache_2way_wb_if.sv
// data_cache_2way_wb_if: core load/store port and word-wide memory port of the 2-way write-back cache
interface data_cache_2way_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              RE;
    logic              WE;
    logic [DATA_W-1:0] WD;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] RD;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic              mem_ack;

    modport slave (
        input  RE, WE, WD, addr, mem_rd, mem_ack,
        output RD, stall, mem_req, mem_we, mem_addr, mem_wd
    );

    modport master (
        output RE, WE, WD, addr, mem_rd, mem_ack,
        input  RD, stall, mem_req, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/data_cache_2way_wb.sv
// data_cache_2way_wb: 2-way set-associative write-back/write-allocate L1 data cache with LRU and burst refill/writeback
// Optional hit/miss/writeback counters are built when CACHE_STATS_EN is defined.
module data_cache_2way_wb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int SETS_LOG2  = 4,
    parameter int WORDS_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_cache_2way_wb_if.slave  bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt,
    output logic [31:0]          wb_cnt
`endif
);
    localparam int SETS  = 1 << SETS_LOG2;
    localparam int WORDS = 1 << WORDS_LOG2;
    localparam int TAG_W = ADDR_W - SETS_LOG2 - WORDS_LOG2 - 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WB     = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    logic [DATA_W-1:0]     r_data  [2][SETS][WORDS];
    logic [TAG_W-1:0]      r_tag   [2][SETS];
    logic [SETS-1:0]       r_valid [2];
    logic [SETS-1:0]       r_dirty [2];
    logic [SETS-1:0]       r_lru;
    logic [1:0]            r_state;
    logic [WORDS_LOG2-1:0] r_cnt;
    logic                  r_gap;
    logic                  r_vic;
    logic [DATA_W-1:0]     r_rd;

    logic [WORDS_LOG2-1:0] w_off;
    logic [SETS_LOG2-1:0]  w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit0, w_hit1, w_hit, w_hway, w_req, w_idle;
    logic                  w_acc, w_miss, w_vic, w_bus, w_ack, w_last, w_wb;
    logic [DATA_W-1:0]     w_word;
    logic                  w_unused;

    assign w_off    = bus.addr[WORDS_LOG2+1:2];
    assign w_idx    = bus.addr[WORDS_LOG2+2 +: SETS_LOG2];
    assign w_tag    = bus.addr[ADDR_W-1 -: TAG_W];
    assign w_unused = ^bus.addr[1:0];

    assign w_hit0 = r_valid[0][w_idx] && r_tag[0][w_idx] == w_tag;
    assign w_hit1 = r_valid[1][w_idx] && r_tag[1][w_idx] == w_tag;
    assign w_hit  = w_hit0 || w_hit1;
    assign w_hway = !w_hit0;
    assign w_req  = bus.RE || bus.WE;
    assign w_idle = r_state == S_IDLE;
    assign w_acc  = w_idle && w_req && w_hit;
    assign w_miss = w_idle && w_req && !w_hit;
    // Fill an empty way first; only when both are valid does LRU decide.
    assign w_vic  = !r_valid[0][w_idx] ? 1'b0 : !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_wb   = r_state == S_WB;
    // r_gap forces one idle bus cycle between the writeback and refill bursts.
    assign w_bus  = (w_wb || r_state == S_REFILL) && !r_gap;
    assign w_ack  = w_bus && bus.mem_ack;
    assign w_last = &r_cnt;
    assign w_word = r_data[w_hway][w_idx][w_off];

    assign bus.stall    = reset && (!w_idle || w_miss);
    assign bus.RD       = (w_acc && !bus.WE) ? w_word : r_rd;
    assign bus.mem_req  = w_bus;
    assign bus.mem_we   = w_bus && w_wb;
    assign bus.mem_addr = w_bus ? {(w_wb ? r_tag[r_vic][w_idx] : w_tag), w_idx, r_cnt, 2'b00} : '0;
    assign bus.mem_wd   = (w_bus && w_wb) ? r_data[r_vic][w_idx][r_cnt] : '0;

    // Controller: hit bookkeeping, miss dispatch and burst sequencing; reset aborts any burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_gap      <= 1'b0;
            r_vic      <= 1'b0;
            r_rd       <= '0;
            r_lru      <= '0;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
        end else begin
            r_gap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_lru[w_idx] <= !w_hway;
                        if (bus.WE)
                            r_dirty[w_hway][w_idx] <= 1'b1;
                        else
                            r_rd <= w_word;
                    end
                    if (w_miss) begin
                        r_vic   <= w_vic;
                        r_state <= (r_valid[w_vic][w_idx] && r_dirty[w_vic][w_idx]) ? S_WB : S_REFILL;
                    end
                end
                S_WB: if (w_ack) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_REFILL;
                        r_gap   <= 1'b1;
                    end
                end
                S_REFILL: if (w_ack) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_UPDATE;
                        r_valid[r_vic][w_idx] <= 1'b0;
                    end
                end
                default: begin
                    r_valid[r_vic][w_idx] <= 1'b1;
                    r_dirty[r_vic][w_idx] <= 1'b0;
                    r_state               <= S_IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays: write hits, refill words and the new tag at line install.
    always_ff @(posedge clk) begin
        if (w_acc && bus.WE)
            r_data[w_hway][w_idx][w_off] <= bus.WD;
        if (r_state == S_REFILL && w_ack)
            r_data[r_vic][w_idx][r_cnt] <= bus.mem_rd;
        if (r_state == S_UPDATE)
            r_tag[r_vic][w_idx] <= w_tag;
    end

`ifdef CACHE_STATS_EN
    logic r_missed;

    // Saturating statistics; a request that missed is not counted again when it finally hits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_missed <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            r_missed <= w_miss ? 1'b1 : w_acc ? 1'b0 : r_missed;
            if (w_acc && !r_missed && ~&hit_cnt)
                hit_cnt <= hit_cnt + 1'b1;
            if (w_miss && ~&miss_cnt)
                miss_cnt <= miss_cnt + 1'b1;
            if (w_miss && r_valid[w_vic][w_idx] && r_dirty[w_vic][w_idx] && ~&wb_cnt)
                wb_cnt <= wb_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_data_cache_2way_wb.sv
// tb_data_cache_2way_wb: directed self-checking bench for the 2-way write-back data cache
module tb_data_cache_2way_wb;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_cache_2way_wb_if bus();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    data_cache_2way_wb dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt),
        .wb_cnt  (wb_cnt)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    int          total = 0;
    int          bad = 0;
    int          lat = 0;
    logic [31:0] mem [logic [31:0]];
    txn_t        log_q [$];

    function automatic logic [31:0] memval(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int cyc, output logic fs);
        @(negedge clk);
        bus.WE = we;
        bus.RE = !we;
        bus.addr = a;
        bus.WD = d;
        #1;
        fs = bus.stall;
        cyc = 0;
        while (bus.stall && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("no_timeout", {31'b0, bus.stall}, 32'd0);
        rd = bus.RD;
        @(negedge clk);
        bus.RE = 1'b0;
        bus.WE = 1'b0;
    endtask

    // Memory model: answers each word after lat idle cycles and checks the request is held meanwhile.
    initial begin
        int          w;
        logic [31:0] ha, hd;
        w = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rd = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req) begin
                if (w == 0) begin
                    ha = bus.mem_addr;
                    hd = bus.mem_wd;
                end else begin
                    chk("hold_addr", bus.mem_addr, ha);
                    chk("hold_wd", bus.mem_wd, hd);
                    chk("hold_stall", {31'b0, bus.stall}, 32'd1);
                end
                if (w >= lat) begin
                    if (bus.mem_we) begin
                        mem[bus.mem_addr] = bus.mem_wd;
                        log_q.push_back('{1'b1, bus.mem_addr, bus.mem_wd});
                    end else begin
                        bus.mem_rd = memval(bus.mem_addr);
                        log_q.push_back('{1'b0, bus.mem_addr, bus.mem_rd});
                    end
                    bus.mem_ack = 1'b1;
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, e124;
        int          cyc, n;
        logic        fs;
        bus.RE = 1'b0;
        bus.WE = 1'b0;
        bus.addr = '0;
        bus.WD = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wd", bus.mem_wd, 32'd0);
        chk("rst_rd", bus.RD, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        log_q.delete();
        access(1'b0, 32'h120, 32'h0, rd, cyc, fs);
        chk("cold_stall", {31'b0, fs}, 32'd1);
        chk("cold_n", log_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cold_addr", log_q[i].a, 32'h120 + 32'(4 * i));
            chk("cold_we", {31'b0, log_q[i].we}, 32'd0);
        end
        chk("cold_rd", rd, memval(32'h120));

        log_q.delete();
        access(1'b1, 32'h120, 32'd100, rd, cyc, fs);
        chk("wr_hit_stall", {31'b0, fs}, 32'd0);
        chk("wr_hit_bus", log_q.size(), 32'd0);
        access(1'b0, 32'h120, 32'h0, rd, cyc, fs);
        chk("rd_hit_stall", {31'b0, fs}, 32'd0);
        chk("rd_hit_rd", rd, 32'd100);
        chk("rd_hit_bus", log_q.size(), 32'd0);

        access(1'b0, 32'h220, 32'h0, rd, cyc, fs);
        chk("way1_n", log_q.size(), 32'd4);
        chk("way1_first", log_q[0].a, 32'h220);
        chk("way1_nowb", {31'b0, log_q[0].we}, 32'd0);
        chk("way1_rd", rd, memval(32'h220));
        log_q.delete();
        access(1'b0, 32'h120, 32'h0, rd, cyc, fs);
        chk("keep120_rd", rd, 32'd100);
        chk("keep120_bus", log_q.size(), 32'd0);

        access(1'b0, 32'h320, 32'h0, rd, cyc, fs);
        chk("evict_clean_n", log_q.size(), 32'd4);
        chk("evict_clean_first", log_q[0].a, 32'h320);
        chk("evict_clean_we", {31'b0, log_q[0].we}, 32'd0);
        chk("evict_clean_rd", rd, memval(32'h320));

        log_q.delete();
        e124 = memval(32'h124);
        lat = 5;
        access(1'b0, 32'h420, 32'h0, rd, cyc, fs);
        lat = 0;
        chk("wb_n", log_q.size(), 32'd8);
        for (int i = 0; i < 4; i++) begin
            chk("wb_we", {31'b0, log_q[i].we}, 32'd1);
            chk("wb_addr", log_q[i].a, 32'h120 + 32'(4 * i));
            chk("rf_we", {31'b0, log_q[i+4].we}, 32'd0);
            chk("rf_addr", log_q[i+4].a, 32'h420 + 32'(4 * i));
        end
        chk("wb_wd0", log_q[0].d, 32'd100);
        chk("wb_wd1", log_q[1].d, e124);
        chk("wb_rd", rd, memval(32'h420));
        chk("wb_slow", {31'b0, cyc > 40}, 32'd1);

        repeat (3) @(negedge clk);
        #1;
        chk("rd_hold", bus.RD, memval(32'h420));
`ifdef CACHE_STATS_EN
        chk("stat_hit", hit_cnt, 32'd3);
        chk("stat_miss", miss_cnt, 32'd4);
        chk("stat_wb", wb_cnt, 32'd1);
`endif

        log_q.delete();
        lat = 3;
        @(negedge clk);
        bus.RE = 1'b1;
        bus.addr = 32'h520;
        n = 0;
        while (log_q.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("mid_refill", {31'b0, bus.mem_req && !bus.mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_req", {31'b0, bus.mem_req}, 32'd0);
        chk("abort_stall", {31'b0, bus.stall}, 32'd0);
        chk("abort_addr", bus.mem_addr, 32'd0);
`ifdef CACHE_STATS_EN
        chk("abort_hit", hit_cnt, 32'd0);
        chk("abort_miss", miss_cnt, 32'd0);
        chk("abort_wb", wb_cnt, 32'd0);
`endif
        bus.RE = 1'b0;
        lat = 0;
        @(negedge clk);
        reset = 1'b1;

        log_q.delete();
        access(1'b0, 32'h120, 32'h0, rd, cyc, fs);
        chk("post_rst_stall", {31'b0, fs}, 32'd1);
        chk("post_rst_n", log_q.size(), 32'd4);
        chk("post_rst_rd", rd, 32'd100);
        log_q.delete();
        access(1'b0, 32'h520, 32'h0, rd, cyc, fs);
        chk("no_partial_n", log_q.size(), 32'd4);
        chk("no_partial_rd", rd, memval(32'h520));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
